sha256_job_sched: RTL and testbench

//  Job scheduler in front of simplified_sha256. Queues hash jobs (message/output address

---
 rtl/sha256_job_sched.sv | 106 ++++++++++
 tb/tb_sha256_job_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_job_sched.sv
// sha256_job_sched: FIFO-queued tagged job launcher for a single SHA core; SHA_SCHED_TIMEOUT_EN adds a WAIT timeout.
module sha256_job_sched #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 16,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [ADDR_W-1:0]        job_msg_addr,
  input  logic [ADDR_W-1:0]        job_out_addr,
  input  logic [TAG_W-1:0]         job_tag,
  output logic                     core_start,
  output logic [ADDR_W-1:0]        core_msg_addr,
  output logic [ADDR_W-1:0]        core_out_addr,
  input  logic                     core_done,
  output logic                     cmp_valid,
  input  logic                     cmp_ready,
  output logic [TAG_W-1:0]         cmp_tag,
  output logic                     cmp_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * ADDR_W + TAG_W;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} state_t;
  state_t state, state_nx;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic push, pop, full, empty, to;

  assign full       = pending == CW'(DEPTH);
  assign empty      = pending == '0;
  assign job_ready  = !full;
  assign push       = job_valid && !full;
  assign pop        = state == IDLE && !empty;
  assign core_start = state == LAUNCH;
  assign cmp_valid  = state == REPORT;
  assign busy       = state != IDLE;

  always_ff @(posedge clk)
    if (push) mem[wp] <= {job_msg_addr, job_out_addr, job_tag};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp      <= '0;
      rp      <= '0;
      pending <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      pending <= pending + CW'(push) - CW'(pop);
    end

  // the tag register doubles as cmp_tag; all three hold from pop until the next pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      core_msg_addr <= '0;
      core_out_addr <= '0;
      cmp_tag       <= '0;
    end else if (pop) begin
      {core_msg_addr, core_out_addr, cmp_tag} <= mem[rp];
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = empty ? IDLE : LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = (core_done || to) ? REPORT : WAIT;
      REPORT:  state_nx = cmp_ready ? IDLE : REPORT;
      default: state_nx = IDLE;
    endcase
  end

`ifdef SHA_SCHED_TIMEOUT_EN
  logic [31:0] cnt;

  assign to = state == WAIT && cnt == 32'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (state == LAUNCH) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;

  // done in the same cycle as the timeout still reports success
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cmp_err <= 1'b0;
    else if (state == WAIT && (core_done || to)) cmp_err <= !core_done;
`else
  logic unused_timeout;

  assign to             = 1'b0;
  assign cmp_err        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif
endmodule

// File: tb/tb_sha256_job_sched.sv
// tb_sha256_job_sched: scoreboard bench; expected jobs queued on push, checked at launch and completion.
module tb_sha256_job_sched;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int TW    = 4;
  localparam int TO    = 16;
`ifdef SHA_SCHED_TIMEOUT_EN
  localparam int SINGLE_WAIT = 10;
`else
  localparam int SINGLE_WAIT = 500;
`endif

  logic clk = 0, reset_n = 0, job_valid = 0, core_done = 0, cmp_ready = 0;
  logic [AW-1:0] job_msg_addr = 0, job_out_addr = 0;
  logic [TW-1:0] job_tag = 0;
  logic job_ready, core_start, cmp_valid, cmp_err, busy;
  logic [AW-1:0] core_msg_addr, core_out_addr;
  logic [TW-1:0] cmp_tag;
  logic [$clog2(DEPTH):0] pending;

  typedef struct packed {logic [AW-1:0] m; logic [AW-1:0] o; logic [TW-1:0] t;} job_t;
  job_t q[$];
  job_t e;
  int tests = 0, fails = 0;

  sha256_job_sched #(.DEPTH(DEPTH), .ADDR_W(AW), .TAG_W(TW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr), .job_tag(job_tag),
    .core_start(core_start), .core_msg_addr(core_msg_addr), .core_out_addr(core_out_addr),
    .core_done(core_done), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
    .cmp_err(cmp_err), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    logic acc;
    acc = job_valid && job_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back({job_msg_addr, job_out_addr, job_tag});
      job_valid = 0;
    end
  endtask

  task automatic offer(input logic [AW-1:0] m, input logic [AW-1:0] o, input logic [TW-1:0] t);
    job_msg_addr = m;
    job_out_addr = o;
    job_tag      = t;
    job_valid    = 1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!core_start && n < 200) begin tick; n++; end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) tick;
    tests++; if (pending !== 0) begin fails++; $display("FAIL reset_pending: got %0d want 0", pending); end
    tests++; if (job_ready !== 1) begin fails++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    tests++; if (core_start !== 0) begin fails++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    tests++; if (cmp_valid !== 0) begin fails++; $display("FAIL reset_cmp_valid: got %b want 0", cmp_valid); end
    tests++; if (busy !== 0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (cmp_err !== 0) begin fails++; $display("FAIL reset_cmp_err: got %b want 0", cmp_err); end
    reset_n = 1;
    tick;
  endtask

  task automatic test_single;
    offer(16'h0010, 16'h0100, 4'd3);
    tick;
    tests++; if (core_start !== 0) begin fails++; $display("FAIL single_n1_start: got %b want 0", core_start); end
    tick;
    tests++; if (core_start !== 1) begin fails++; $display("FAIL single_n2_start: got %b want 1", core_start); end
    tests++; if (core_msg_addr !== 16'h0010) begin fails++; $display("FAIL single_msg_addr: got %h want 0010", core_msg_addr); end
    tests++; if (core_out_addr !== 16'h0100) begin fails++; $display("FAIL single_out_addr: got %h want 0100", core_out_addr); end
    tick;
    tests++; if (core_start !== 0 || busy !== 1) begin fails++; $display("FAIL single_wait: start %b busy %b want 0 1", core_start, busy); end
    repeat (SINGLE_WAIT - 1) tick;
    core_done = 1;
    tick;
    core_done = 0;
    e = q.size() > 0 ? q[0] : 'x;
    tests++; if (cmp_valid !== 1) begin fails++; $display("FAIL single_cmp_valid: got %b want 1", cmp_valid); end
    tests++; if (cmp_tag !== 4'd3 || cmp_tag !== e.t) begin fails++; $display("FAIL single_cmp_tag: got %h want 3", cmp_tag); end
    tests++; if (cmp_err !== 0) begin fails++; $display("FAIL single_cmp_err: got %b want 0", cmp_err); end
    cmp_ready = 1;
    tick;
    cmp_ready = 0;
    if (q.size() > 0) e = q.pop_front();
    tests++; if (cmp_valid !== 0 || busy !== 0) begin fails++; $display("FAIL single_idle: valid %b busy %b want 0 0", cmp_valid, busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    offer(16'h1000, 16'h2000, 4'd8);
    wait_start(n);
    tick;
    for (int i = 1; i <= 4; i++) begin
      offer(16'h1000 + AW'(i), 16'h2000 + AW'(i), TW'(i));
      tick;
    end
    tests++; if (pending !== 4) begin fails++; $display("FAIL b2b_pending_full: got %0d want 4", pending); end
    tests++; if (job_ready !== 0) begin fails++; $display("FAIL b2b_ready_full: got %b want 0", job_ready); end
    offer(16'h1005, 16'h2005, 4'd5);
    repeat (3) tick;
    tests++; if (pending !== 4 || job_valid !== 1) begin fails++; $display("FAIL b2b_fifth_held: pending %0d valid %b want 4 1", pending, job_valid); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        wait_start(n);
        tests++; if (core_start !== 1 || n !== 1) begin fails++; $display("FAIL b2b_start%0d: start %b after %0d cycles want 1 after 1", k, core_start, n); end
        tick;
      end
      e = q.size() > 0 ? q[0] : 'x;
      tests++; if (core_msg_addr !== e.m || core_out_addr !== e.o) begin fails++; $display("FAIL b2b_addr%0d: got %h/%h want %h/%h", k, core_msg_addr, core_out_addr, e.m, e.o); end
      core_done = 1;
      tick;
      core_done = 0;
      tests++; if (cmp_valid !== 1 || cmp_tag !== e.t) begin fails++; $display("FAIL b2b_tag%0d: valid %b tag %h want 1 %h", k, cmp_valid, cmp_tag, e.t); end
      cmp_ready = 1;
      tick;
      cmp_ready = 0;
      if (q.size() > 0) e = q.pop_front();
    end
    tests++; if (busy !== 0 || pending !== 0) begin fails++; $display("FAIL b2b_drained: busy %b pending %0d want 0 0", busy, pending); end
  endtask

  task automatic test_hold;
    int n;
    offer(16'h3000, 16'h4000, 4'd6);
    wait_start(n);
    tick;
    core_done = 1;
    tick;
    core_done = 0;
    tests++; if (pending !== 0) begin fails++; $display("FAIL hold_pending_before: got %0d want 0", pending); end
    offer(16'h3001, 16'h4001, 4'd7);
    for (int i = 0; i < 10; i++) begin
      tests++; if (cmp_valid !== 1 || cmp_tag !== 4'd6 || core_start !== 0) begin fails++; $display("FAIL hold_cycle%0d: valid %b tag %h start %b want 1 6 0", i, cmp_valid, cmp_tag, core_start); end
      tick;
    end
    tests++; if (pending !== 1) begin fails++; $display("FAIL hold_pending_after: got %0d want 1", pending); end
    cmp_ready = 1;
    tick;
    cmp_ready = 0;
    if (q.size() > 0) e = q.pop_front();
    wait_start(n);
    e = q.size() > 0 ? q[0] : 'x;
    tests++; if (core_start !== 1 || core_msg_addr !== 16'h3001 || core_msg_addr !== e.m) begin fails++; $display("FAIL hold_next_start: start %b addr %h want 1 3001", core_start, core_msg_addr); end
    tick;
    core_done = 1;
    tick;
    core_done = 0;
    tests++; if (cmp_valid !== 1 || cmp_tag !== 4'd7) begin fails++; $display("FAIL hold_next_tag: valid %b tag %h want 1 7", cmp_valid, cmp_tag); end
    cmp_ready = 1;
    tick;
    cmp_ready = 0;
    if (q.size() > 0) e = q.pop_front();
  endtask

  task automatic test_spurious;
    core_done = 1;
    tick;
    tests++; if (busy !== 0 || cmp_valid !== 0) begin fails++; $display("FAIL spur_idle: busy %b valid %b want 0 0", busy, cmp_valid); end
    offer(16'h5000, 16'h6000, 4'd9);
    tick;
    tick;
    tests++; if (core_start !== 1) begin fails++; $display("FAIL spur_launch: got %b want 1", core_start); end
    tick;
    core_done = 0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (cmp_valid !== 0 || busy !== 1) begin fails++; $display("FAIL spur_wait%0d: valid %b busy %b want 0 1", i, cmp_valid, busy); end
      tick;
    end
    core_done = 1;
    tick;
    core_done = 0;
    tests++; if (cmp_valid !== 1 || cmp_tag !== 4'd9) begin fails++; $display("FAIL spur_done: valid %b tag %h want 1 9", cmp_valid, cmp_tag); end
    cmp_ready = 1;
    tick;
    cmp_ready = 0;
    if (q.size() > 0) e = q.pop_front();
  endtask

  task automatic test_reset_mid;
    int n;
    offer(16'h7000, 16'h8000, 4'd12);
    wait_start(n);
    tick;
    offer(16'h7001, 16'h8001, 4'd10);
    tick;
    offer(16'h7002, 16'h8002, 4'd11);
    tick;
    tests++; if (pending !== 2 || busy !== 1) begin fails++; $display("FAIL rmid_queued: pending %0d busy %b want 2 1", pending, busy); end
    reset_n = 0;
    #1;
    tests++; if (pending !== 0 || busy !== 0) begin fails++; $display("FAIL rmid_immediate: pending %0d busy %b want 0 0", pending, busy); end
    tests++; if (job_ready !== 1 || cmp_valid !== 0 || core_start !== 0) begin fails++; $display("FAIL rmid_outputs: ready %b valid %b start %b want 1 0 0", job_ready, cmp_valid, core_start); end
    q.delete();
    tick;
    reset_n = 1;
    core_done = 1;
    tick;
    core_done = 0;
    repeat (3) tick;
    tests++; if (cmp_valid !== 0 || busy !== 0 || pending !== 0) begin fails++; $display("FAIL rmid_after: valid %b busy %b pending %0d want 0 0 0", cmp_valid, busy, pending); end
  endtask

`ifdef SHA_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    offer(16'h9000, 16'hA000, 4'd13);
    wait_start(n);
    n = 0;
    while (!cmp_valid && n < 100) begin tick; n++; end
    tests++; if (cmp_valid !== 1 || cmp_err !== 1 || n !== TO + 1) begin fails++; $display("FAIL to_expire: valid %b err %b after %0d want 1 1 after %0d", cmp_valid, cmp_err, n, TO + 1); end
    tests++; if (cmp_tag !== 4'd13) begin fails++; $display("FAIL to_tag: got %h want d", cmp_tag); end
    cmp_ready = 1;
    tick;
    cmp_ready = 0;
    if (q.size() > 0) e = q.pop_front();
    core_done = 1;
    tick;
    core_done = 0;
    tests++; if (cmp_valid !== 0 || busy !== 0) begin fails++; $display("FAIL to_late_done: valid %b busy %b want 0 0", cmp_valid, busy); end
    offer(16'h9001, 16'hA001, 4'd14);
    wait_start(n);
    repeat (TO) tick;
    core_done = 1;
    tick;
    core_done = 0;
    tests++; if (cmp_valid !== 1 || cmp_err !== 0 || cmp_tag !== 4'd14) begin fails++; $display("FAIL to_done_wins: valid %b err %b tag %h want 1 0 e", cmp_valid, cmp_err, cmp_tag); end
    cmp_ready = 1;
    tick;
    cmp_ready = 0;
    if (q.size() > 0) e = q.pop_front();
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_hold;
    test_spurious;
    test_reset_mid;
`ifdef SHA_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
